// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: fetch, halt check, single-cycle issue, wait for completions.
// Optional watchdog on the WAIT state is enabled by defining EXEC_WDOG_EN.
module exec_sequencer #(
  parameter int unsigned FETCH_LAT   = 2,
  parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] op_in,
  output logic        d_valid,
  output logic [31:0] op,
  input  logic        write_finish,
  input  logic        load_finish,
  input  logic        store_finish,
  input  logic        jump_finish,
  input  logic        uart_tx_done,
  output logic        busy,
  output logic        halted,
  output logic [31:0] retired,
  output logic        wdog_err
);

  localparam int unsigned CntW = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;

  typedef enum logic [2:0] {StIdle, StFetch, StCheck, StIssue, StWait, StHalt} state_e;

  // Done-flag bit positions: {uart, jump, store, load, write}
  localparam int unsigned FlWrite = 0;
  localparam int unsigned FlLoad  = 1;
  localparam int unsigned FlStore = 2;
  localparam int unsigned FlJump  = 3;
  localparam int unsigned FlUart  = 4;

  state_e            state_q, state_d;
  logic [CntW-1:0]   fetch_cnt_q, fetch_cnt_d;
  logic [31:0]       op_q, op_d;
  logic [4:0]        flags_q, flags_d;
  logic [31:0]       retired_q, retired_d;
  logic [4:0]        pulses;
  logic [4:0]        req;
  logic              all_done;
  logic [5:0]        opcode;
  logic [5:0]        funct;

  assign pulses = {uart_tx_done, jump_finish, store_finish, load_finish, write_finish};
  assign opcode = op_q[31:26];
  assign funct  = op_q[5:0];

  // Completion set the latched op has to see before it retires.
  always_comb begin
    req = '0;
    req[FlJump] = 1'b1;
    case (opcode)
      6'b000000: if (funct != 6'b001000) req[FlWrite] = 1'b1;
      6'b001000, 6'b001010, 6'b001111, 6'b000011: req[FlWrite] = 1'b1;
      6'b010001: if (funct != 6'b010000 && funct != 6'b010001) req[FlWrite] = 1'b1;
      6'b100011, 6'b110001: begin
        req[FlWrite] = 1'b1;
        req[FlLoad]  = 1'b1;
      end
      6'b101011, 6'b111001: req[FlStore] = 1'b1;
      6'b110010: req[FlWrite] = 1'b1;
      6'b111010: req[FlUart]  = 1'b1;
      default: ;
    endcase
  end

  assign all_done = ((flags_q & req) == req);

`ifdef EXEC_WDOG_EN
  logic [31:0] wdog_cnt_q, wdog_cnt_d;
  logic        wdog_err_q, wdog_err_d;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      fetch_cnt_q <= '0;
      op_q        <= '0;
      flags_q     <= '0;
      retired_q   <= '0;
`ifdef EXEC_WDOG_EN
      wdog_cnt_q  <= '0;
      wdog_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      fetch_cnt_q <= fetch_cnt_d;
      op_q        <= op_d;
      flags_q     <= flags_d;
      retired_q   <= retired_d;
`ifdef EXEC_WDOG_EN
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_err_q  <= wdog_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_cnt_d = fetch_cnt_q;
    op_d        = op_q;
    flags_d     = flags_q;
    retired_d   = retired_q;
`ifdef EXEC_WDOG_EN
    wdog_cnt_d  = wdog_cnt_q;
    wdog_err_d  = wdog_err_q;
`endif
    case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          state_d     = StFetch;
          fetch_cnt_d = '0;
        end
      end
      StFetch: begin
        if (fetch_cnt_q == CntW'(FETCH_LAT - 1)) begin
          op_d        = op_in;
          fetch_cnt_d = '0;
          state_d     = StCheck;
        end else begin
          fetch_cnt_d = fetch_cnt_q + CntW'(1);
        end
      end
      StCheck: state_d = (op_q == HALT_WORD) ? StHalt : StIssue;
      StIssue: begin
        // Pulses coincident with issue already count toward completion.
        flags_d = pulses;
        state_d = StWait;
`ifdef EXEC_WDOG_EN
        wdog_cnt_d = '0;
`endif
      end
      StWait: begin
        flags_d = flags_q | pulses;
        if (all_done) begin
          retired_d = retired_q + 32'd1;
          state_d   = StFetch;
`ifdef EXEC_WDOG_EN
        end else if (wdog_cnt_q == 32'(WDOG_CYCLES - 1)) begin
          wdog_err_d = 1'b1;
          state_d    = StHalt;
        end else begin
          wdog_cnt_d = wdog_cnt_q + 32'd1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    d_valid = (state_q == StIssue);
    busy    = (state_q == StFetch) || (state_q == StCheck) ||
              (state_q == StIssue) || (state_q == StWait);
    halted  = (state_q == StHalt);
    op      = op_q;
    retired = retired_q;
`ifdef EXEC_WDOG_EN
    wdog_err = wdog_err_q;
`else
    wdog_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer (FETCH_LAT=2, WDOG_CYCLES=16).
// Watchdog expectations follow EXEC_WDOG_EN, defined or not.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_in = '0;
  logic        d_valid;
  logic [31:0] op;
  logic        write_finish = 1'b0;
  logic        load_finish = 1'b0;
  logic        store_finish = 1'b0;
  logic        jump_finish = 1'b0;
  logic        uart_tx_done = 1'b0;
  logic        busy;
  logic        halted;
  logic [31:0] retired;
  logic        wdog_err;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] OpAdd  = 32'h0022_1820;
  localparam logic [31:0] OpLw   = 32'h8C22_0004;
  localparam logic [31:0] OpSw   = 32'hAC22_0008;
  localparam logic [31:0] OpSwc2 = 32'hE800_0000;
  localparam logic [31:0] OpJr   = 32'h03E0_0008;
  localparam logic [31:0] OpHalt = 32'hFFFF_FFFF;

  exec_sequencer #(
    .FETCH_LAT  (2),
    .HALT_WORD  (32'hFFFF_FFFF),
    .WDOG_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .op_in       (op_in),
    .d_valid     (d_valid),
    .op          (op),
    .write_finish(write_finish),
    .load_finish (load_finish),
    .store_finish(store_finish),
    .jump_finish (jump_finish),
    .uart_tx_done(uart_tx_done),
    .busy        (busy),
    .halted      (halted),
    .retired     (retired),
    .wdog_err    (wdog_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // From FETCH count 0: two fetch cycles, CHECK, then ISSUE.
  task automatic run_to_issue(input string tag);
    step();
    step();
    step();
    chk(tag, {31'd0, d_valid}, 32'd1);
  endtask

  initial begin
    // Reset state
    step();
    chk("rst_dvalid", {31'd0, d_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_op", op, 32'd0);
    chk("rst_wdog", {31'd0, wdog_err}, 32'd0);
    rstn = 1'b1;
    step();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // 1: ADD, write+jump in the same cycle
    op_in = OpAdd;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_fetch_busy", {31'd0, busy}, 32'd1);
    chk("t1_fetch_dv", {31'd0, d_valid}, 32'd0);
    step();
    step();
    chk("t1_op_latched", op, OpAdd);
    chk("t1_check_dv", {31'd0, d_valid}, 32'd0);
    step();
    chk("t1_issue_dv", {31'd0, d_valid}, 32'd1);
    write_finish = 1'b1;
    jump_finish  = 1'b1;
    step();
    write_finish = 1'b0;
    jump_finish  = 1'b0;
    chk("t1_wait_dv", {31'd0, d_valid}, 32'd0);
    chk("t1_wait_ret", retired, 32'd0);
    step();
    chk("t1_retired", retired, 32'd1);
    chk("t1_refetch_busy", {31'd0, busy}, 32'd1);

    // 2: LW; jump +1, load +3, write +5
    op_in = OpLw;
    run_to_issue("t2_issue_dv");
    chk("t2_op", op, OpLw);
    step();
    jump_finish = 1'b1;
    step();
    jump_finish = 1'b0;
    step();
    load_finish = 1'b1;
    step();
    load_finish = 1'b0;
    chk("t2_wait_ret", retired, 32'd1);
    step();
    write_finish = 1'b1;
    step();
    write_finish = 1'b0;
    chk("t2_flags_set_ret", retired, 32'd1);
    chk("t2_still_busy", {31'd0, busy}, 32'd1);
    step();
    chk("t2_retired", retired, 32'd2);

    // 3: SW; write+jump alone must not retire
    op_in = OpSw;
    run_to_issue("t3_issue_dv");
    write_finish = 1'b1;
    jump_finish  = 1'b1;
    step();
    write_finish = 1'b0;
    jump_finish  = 1'b0;
    step();
    step();
    chk("t3_no_store_ret", retired, 32'd2);
    write_finish = 1'b1;
    step();
    write_finish = 1'b0;
    step();
    chk("t3_spurious_ret", retired, 32'd2);
    store_finish = 1'b1;
    step();
    store_finish = 1'b0;
    step();
    chk("t3_retired", retired, 32'd3);

    // 4: halt word
    op_in = OpHalt;
    step();
    step();
    chk("t4_check_dv", {31'd0, d_valid}, 32'd0);
    step();
    chk("t4_halted", {31'd0, halted}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_dv", {31'd0, d_valid}, 32'd0);
    jump_finish = 1'b1;
    step();
    jump_finish = 1'b0;
    step();
    chk("t4_hold", {31'd0, halted}, 32'd1);
    chk("t4_ret", retired, 32'd3);
    op_in = OpSwc2;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_resume_halted", {31'd0, halted}, 32'd0);
    chk("t4_resume_busy", {31'd0, busy}, 32'd1);

    // 5: async reset during WAIT of SWC2
    run_to_issue("t5_issue_dv");
    step();
    step();
    chk("t5_in_wait", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("t5_rst_ret", retired, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_op", op, 32'd0);
    chk("t5_rst_halted", {31'd0, halted}, 32'd0);
    step();
    rstn = 1'b1;
    step();

    // 6: SWC2 with no uart_tx_done
    op_in = OpSwc2;
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_issue("t6_issue_dv");
    jump_finish = 1'b1;
    step();
    jump_finish = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("t6_wait15_halted", {31'd0, halted}, 32'd0);
    chk("t6_wait15_err", {31'd0, wdog_err}, 32'd0);
    step();
`ifdef EXEC_WDOG_EN
    chk("t6_wdog_err", {31'd0, wdog_err}, 32'd1);
    chk("t6_halted", {31'd0, halted}, 32'd1);
    chk("t6_ret", retired, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_sticky", {31'd0, wdog_err}, 32'd1);
`else
    chk("t6_no_wdog_err", {31'd0, wdog_err}, 32'd0);
    chk("t6_still_busy", {31'd0, busy}, 32'd1);
    uart_tx_done = 1'b1;
    step();
    uart_tx_done = 1'b0;
    step();
    chk("t6_uart_ret", retired, 32'd1);
`endif
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();

    // 7: JR at minimum period (jump pulse in the issue cycle)
    op_in = OpJr;
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_issue("t7_issue_dv");
    jump_finish = 1'b1;
    step();
    jump_finish = 1'b0;
    chk("t7_wait_ret", retired, 32'd0);
    step();
    chk("t7_retired", retired, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
